bus_node_fifo_port: RTL and testbench

// - Per-node endpoint between one device and the shared bus arbiter (one instance per drvrs slot).
// - TX side: device writes packets into a queue; the block presents pndng/D_pop and the arbiter drains it with pop.
// - RX side: captures push/D_push deliveries into a receive queue the device reads.
// - Synthesizable counterpart of the bench-side driver/monitor queues; feeds and consumes the bus DUT directly.

---
 rtl/bus_node_fifo_port.sv | 197 +++++++++++++++++++
 tb/tb_bus_node_fifo_port.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_node_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : bus_node_fifo_port
// Purpose  : Per-node endpoint between one device and the shared bus arbiter.
//            TX side queues device packets and presents them to the arbiter
//            (pndng / D_pop, drained by pop). RX side captures arbiter
//            deliveries (push / D_push) into a queue the device reads.
//            Both queues are first-word fall-through; data outputs read 0
//            while the corresponding queue is empty.
// Ports    : clk, reset (sync, active-high)
//            dev_wr, dev_wr_data, dev_full          - device -> TX queue
//            pndng, D_pop, pop                      - TX queue <-> arbiter
//            push, D_push                           - arbiter -> RX queue
//            dev_rd, dev_rd_data, dev_rx_vld        - RX queue -> device
//            tx_count, rx_count                     - occupancies 0..DEPTH
//            err_flags                              - sticky {rx_ovf, tx_undf, tx_ovf}
// Config   : RX_ADDR_FILTER_EN - when defined, a push is accepted only if its
//            destination byte equals DRVR_ID or BROADCAST; other pushes are
//            silently dropped. When undefined, every push is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module bus_node_fifo_port #(
    parameter int         PCKG_SZ   = 16,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] DRVR_ID   = 8'd0,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dev_wr,
    input  logic [PCKG_SZ-1:0]           dev_wr_data,
    output logic                         dev_full,
    output logic                         pndng,
    output logic [PCKG_SZ-1:0]           D_pop,
    input  logic                         pop,
    input  logic                         push,
    input  logic [PCKG_SZ-1:0]           D_push,
    input  logic                         dev_rd,
    output logic [PCKG_SZ-1:0]           dev_rd_data,
    output logic                         dev_rx_vld,
    output logic [$clog2(DEPTH+1)-1:0]   tx_count,
    output logic [$clog2(DEPTH+1)-1:0]   rx_count,
    output logic [2:0]                   err_flags
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

`ifdef RX_ADDR_FILTER_EN
    localparam logic c_filter_en = 1'b1;
`else
    localparam logic c_filter_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage and pointer/count state
    // ------------------------------------------------------------------
    logic [PCKG_SZ-1:0] r_tx_mem [DEPTH];
    logic [PCKG_SZ-1:0] r_rx_mem [DEPTH];

    logic [PTR_W-1:0] r_tx_wr_ptr;
    logic [PTR_W-1:0] r_tx_rd_ptr;
    logic [CNT_W-1:0] r_tx_count;
    logic [PTR_W-1:0] r_rx_wr_ptr;
    logic [PTR_W-1:0] r_rx_rd_ptr;
    logic [CNT_W-1:0] r_rx_count;
    logic [2:0]       r_err;

    // ------------------------------------------------------------------
    // TX decode
    // ------------------------------------------------------------------
    logic w_tx_empty;
    logic w_tx_full;
    logic w_tx_do_pop;
    logic w_tx_do_wr;

    assign w_tx_empty  = (r_tx_count == '0);
    assign w_tx_full   = (r_tx_count == c_cnt_full);
    assign w_tx_do_pop = pop && !w_tx_empty;
    // A pop in the same cycle frees the slot the write needs.
    assign w_tx_do_wr  = dev_wr && (!w_tx_full || w_tx_do_pop);

    // ------------------------------------------------------------------
    // RX decode
    // ------------------------------------------------------------------
    logic [7:0] w_dest;
    logic       w_addr_ok;
    logic       w_rx_accept;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_rx_do_rd;
    logic       w_rx_do_wr;

    assign w_dest      = D_push[PCKG_SZ-1 -: 8];
    assign w_addr_ok   = (w_dest == DRVR_ID) || (w_dest == BROADCAST);
    // Filtered-out pushes never reach the queue, so they cannot overflow it.
    assign w_rx_accept = push && (!c_filter_en || w_addr_ok);
    assign w_rx_empty  = (r_rx_count == '0);
    assign w_rx_full   = (r_rx_count == c_cnt_full);
    assign w_rx_do_rd  = dev_rd && !w_rx_empty;
    assign w_rx_do_wr  = w_rx_accept && (!w_rx_full || w_rx_do_rd);

    // ------------------------------------------------------------------
    // Data storage (no reset needed: contents are qualified by the counts)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_tx_do_wr) begin
            r_tx_mem[r_tx_wr_ptr] <= dev_wr_data;
        end
        if (!reset && w_rx_do_wr) begin
            r_rx_mem[r_rx_wr_ptr] <= D_push;
        end
    end

    // ------------------------------------------------------------------
    // TX pointers / count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_do_wr) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + c_ptr_one;
            end
            if (w_tx_do_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + c_ptr_one;
            end
            case ({w_tx_do_wr, w_tx_do_pop})
                2'b10:   r_tx_count <= r_tx_count + c_cnt_one;
                2'b01:   r_tx_count <= r_tx_count - c_cnt_one;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX pointers / count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_do_wr) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + c_ptr_one;
            end
            if (w_rx_do_rd) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + c_ptr_one;
            end
            case ({w_rx_do_wr, w_rx_do_rd})
                2'b10:   r_rx_count <= r_rx_count + c_cnt_one;
                2'b01:   r_rx_count <= r_rx_count - c_cnt_one;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags {rx_ovf, tx_undf, tx_ovf}
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            if (dev_wr && w_tx_full && !pop) begin
                r_err[0] <= 1'b1;
            end
            if (pop && w_tx_empty) begin
                r_err[1] <= 1'b1;
            end
            if (w_rx_accept && w_rx_full && !dev_rd) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: direct decode of registered state
    // ------------------------------------------------------------------
    assign pndng       = !w_tx_empty;
    assign dev_full    = w_tx_full;
    assign D_pop       = w_tx_empty ? '0 : r_tx_mem[r_tx_rd_ptr];
    assign dev_rx_vld  = !w_rx_empty;
    assign dev_rd_data = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
    assign tx_count    = r_tx_count;
    assign rx_count    = r_rx_count;
    assign err_flags   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_node_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_node_fifo_port
// Purpose  : Self-checking bench for bus_node_fifo_port (node ID 3). Directed
//            scenarios with constant expectations, then a randomized run
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_node_fifo_port;

    localparam int         PW    = 16;
    localparam int         DEPTH = 8;
    localparam int         CW    = $clog2(DEPTH + 1);
    localparam logic [7:0] MY_ID = 8'd3;
    localparam logic [7:0] BCAST = 8'hFF;

`ifdef RX_ADDR_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          dev_wr;
    logic [PW-1:0] dev_wr_data;
    logic          dev_full;
    logic          pndng;
    logic [PW-1:0] D_pop;
    logic          pop;
    logic          push;
    logic [PW-1:0] D_push;
    logic          dev_rd;
    logic [PW-1:0] dev_rd_data;
    logic          dev_rx_vld;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic [2:0]    err_flags;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [PW-1:0] m_tx[$];
    logic [PW-1:0] m_rx[$];
    logic [2:0]    m_err;

    bus_node_fifo_port #(
        .PCKG_SZ  (PW),
        .DEPTH    (DEPTH),
        .DRVR_ID  (MY_ID),
        .BROADCAST(BCAST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dev_wr     (dev_wr),
        .dev_wr_data(dev_wr_data),
        .dev_full   (dev_full),
        .pndng      (pndng),
        .D_pop      (D_pop),
        .pop        (pop),
        .push       (push),
        .D_push     (D_push),
        .dev_rd     (dev_rd),
        .dev_rd_data(dev_rd_data),
        .dev_rx_vld (dev_rx_vld),
        .tx_count   (tx_count),
        .rx_count   (rx_count),
        .err_flags  (err_flags)
    );

    always #5 clk = ~clk;

    // Queue-level behaviour of one clock edge given the current inputs.
    task automatic model_step();
        bit tx_pop_ok, rx_rd_ok, rx_acc;
        if (reset) begin
            m_tx.delete();
            m_rx.delete();
            m_err = 3'b000;
            return;
        end
        tx_pop_ok = pop && (m_tx.size() > 0);
        if (pop && m_tx.size() == 0) m_err[1] = 1'b1;
        if (dev_wr && m_tx.size() == DEPTH && !pop) m_err[0] = 1'b1;
        if (dev_wr && (m_tx.size() < DEPTH || tx_pop_ok)) begin
            if (tx_pop_ok) void'(m_tx.pop_front());
            m_tx.push_back(dev_wr_data);
        end else if (tx_pop_ok) begin
            void'(m_tx.pop_front());
        end
        rx_acc   = push && (!FILTER || D_push[PW-1 -: 8] == MY_ID || D_push[PW-1 -: 8] == BCAST);
        rx_rd_ok = dev_rd && (m_rx.size() > 0);
        if (rx_acc && m_rx.size() == DEPTH && !dev_rd) m_err[2] = 1'b1;
        if (rx_rd_ok) void'(m_rx.pop_front());
        if (rx_acc && (m_rx.size() < DEPTH)) m_rx.push_back(D_push);
    endtask

    // One clock: update model, let the edge happen, settle, drop strobes.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        dev_wr = 1'b0;
        pop    = 1'b0;
        push   = 1'b0;
        dev_rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({pndng, dev_full, dev_rx_vld} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000", {pndng, dev_full, dev_rx_vld});
        end
        checks++;
        if (tx_count !== '0 || rx_count !== '0) begin
            failures++;
            $display("FAIL reset_counts: got tx=%0d rx=%0d want 0/0", tx_count, rx_count);
        end
        checks++;
        if (D_pop !== '0 || dev_rd_data !== '0 || err_flags !== 3'b000) begin
            failures++;
            $display("FAIL reset_data: got D_pop=%h rd=%h err=%b want 0", D_pop, dev_rd_data, err_flags);
        end
    endtask

    task automatic test_tx_basic();
        dev_wr = 1'b1; dev_wr_data = 16'h02AB;
        tick();
        checks++;
        if (pndng !== 1'b1 || D_pop !== 16'h02AB || tx_count !== CW'(1)) begin
            failures++;
            $display("FAIL tx_write: got pndng=%b D_pop=%h cnt=%0d want 1/02ab/1", pndng, D_pop, tx_count);
        end
        pop = 1'b1;
        tick();
        checks++;
        if (pndng !== 1'b0 || D_pop !== 16'h0000 || tx_count !== '0) begin
            failures++;
            $display("FAIL tx_pop: got pndng=%b D_pop=%h cnt=%0d want 0/0000/0", pndng, D_pop, tx_count);
        end
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            dev_wr = 1'b1; dev_wr_data = 16'h0100 + 16'(i);
            tick();
        end
        checks++;
        if (dev_full !== 1'b1 || tx_count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL tx_fill: got full=%b cnt=%0d want 1/8", dev_full, tx_count);
        end
        dev_wr = 1'b1; dev_wr_data = 16'h01FF;
        tick();
        checks++;
        if (err_flags !== 3'b001 || tx_count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL tx_ovf: got err=%b cnt=%0d want 001/8", err_flags, tx_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (D_pop !== 16'h0100 + 16'(i)) begin
                failures++;
                $display("FAIL tx_order[%0d]: got %h want %h", i, D_pop, 16'h0100 + 16'(i));
            end
            pop = 1'b1;
            tick();
        end
    endtask

    task automatic test_tx_full_wr_pop();
        for (int i = 0; i < DEPTH; i++) begin
            dev_wr = 1'b1; dev_wr_data = 16'h0200 + 16'(i);
            tick();
        end
        dev_wr = 1'b1; dev_wr_data = 16'h0A0A; pop = 1'b1;
        tick();
        checks++;
        if (tx_count !== CW'(DEPTH) || D_pop !== 16'h0201 || err_flags[0] !== 1'b1) begin
            failures++;
            $display("FAIL tx_full_wr_pop: got cnt=%0d head=%h want 8/0201", tx_count, D_pop);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            pop = 1'b1;
            tick();
        end
        checks++;
        if (D_pop !== 16'h0A0A || tx_count !== CW'(1)) begin
            failures++;
            $display("FAIL tx_tail: got %h cnt=%0d want 0a0a/1", D_pop, tx_count);
        end
        pop = 1'b1;
        tick();
        pop = 1'b1;
        tick();
        checks++;
        if (err_flags !== 3'b011 || pndng !== 1'b0) begin
            failures++;
            $display("FAIL tx_undf: got err=%b pndng=%b want 011/0", err_flags, pndng);
        end
    endtask

    task automatic test_rx_filter();
        logic [PW-1:0] pkts [3];
        pkts[0] = 16'h0311; pkts[1] = 16'hFF22; pkts[2] = 16'h0533;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; D_push = pkts[i];
            tick();
        end
        checks++;
        if (rx_count !== (FILTER ? CW'(2) : CW'(3)) || err_flags[2] !== 1'b0) begin
            failures++;
            $display("FAIL rx_filter_count: got %0d err=%b want %0d", rx_count, err_flags, FILTER ? 2 : 3);
        end
        for (int i = 0; i < (FILTER ? 2 : 3); i++) begin
            checks++;
            if (dev_rx_vld !== 1'b1 || dev_rd_data !== pkts[i]) begin
                failures++;
                $display("FAIL rx_read[%0d]: got vld=%b %h want 1/%h", i, dev_rx_vld, dev_rd_data, pkts[i]);
            end
            dev_rd = 1'b1;
            tick();
        end
        dev_rd = 1'b1;
        tick();
        checks++;
        if (dev_rx_vld !== 1'b0 || dev_rd_data !== '0 || err_flags[2] !== 1'b0) begin
            failures++;
            $display("FAIL rx_empty_rd: got vld=%b data=%h err=%b want 0/0/0", dev_rx_vld, dev_rd_data, err_flags);
        end
    endtask

    task automatic test_rx_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; D_push = 16'h0300 + 16'(i);
            tick();
        end
        push = 1'b1; D_push = 16'h03EE;
        tick();
        checks++;
        if (err_flags[2] !== 1'b1 || rx_count !== CW'(DEPTH) || dev_rd_data !== 16'h0300) begin
            failures++;
            $display("FAIL rx_ovf: got err=%b cnt=%0d head=%h want 1xx/8/0300", err_flags, rx_count, dev_rd_data);
        end
        push = 1'b1; D_push = 16'hFF55; dev_rd = 1'b1;
        tick();
        checks++;
        if (rx_count !== CW'(DEPTH) || dev_rd_data !== 16'h0301) begin
            failures++;
            $display("FAIL rx_full_push_rd: got cnt=%0d head=%h want 8/0301", rx_count, dev_rd_data);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 5; i++) begin
            dev_wr = 1'b1; dev_wr_data = 16'h0700 + 16'(i);
            tick();
        end
        checks++;
        if (tx_count !== CW'(5) || rx_count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL midop_setup: got tx=%0d rx=%0d want 5/8", tx_count, rx_count);
        end
        reset = 1'b1; dev_wr = 1'b1; dev_wr_data = 16'h0BAD; push = 1'b1; D_push = 16'h03AD;
        tick();
        reset = 1'b0;
        checks++;
        if (tx_count !== '0 || rx_count !== '0 || err_flags !== 3'b000 ||
            pndng !== 1'b0 || dev_rx_vld !== 1'b0 || D_pop !== '0 || dev_rd_data !== '0) begin
            failures++;
            $display("FAIL midop_reset: got tx=%0d rx=%0d err=%b pndng=%b vld=%b want all 0",
                     tx_count, rx_count, err_flags, pndng, dev_rx_vld);
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] exp_dpop, exp_rd;
        logic [7:0]    dest;
        int            bad = 0;
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            dev_wr      = $urandom_range(0, 99) < 55;
            pop         = $urandom_range(0, 99) < 45;
            push        = $urandom_range(0, 99) < 55;
            dev_rd      = $urandom_range(0, 99) < 45;
            dev_wr_data = PW'($urandom);
            case ($urandom_range(0, 2))
                0:       dest = MY_ID;
                1:       dest = BCAST;
                default: dest = 8'($urandom);
            endcase
            D_push = {dest, 8'($urandom)};
            tick();
            reset    = 1'b0;
            exp_dpop = (m_tx.size() > 0) ? m_tx[0] : '0;
            exp_rd   = (m_rx.size() > 0) ? m_rx[0] : '0;
            checks++;
            if (tx_count !== CW'(m_tx.size()) || pndng !== (m_tx.size() > 0) ||
                dev_full !== (m_tx.size() == DEPTH) || D_pop !== exp_dpop) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_tx@%0d: got cnt=%0d pndng=%b full=%b D_pop=%h want cnt=%0d D_pop=%h",
                             n, tx_count, pndng, dev_full, D_pop, m_tx.size(), exp_dpop);
            end
            checks++;
            if (rx_count !== CW'(m_rx.size()) || dev_rx_vld !== (m_rx.size() > 0) ||
                dev_rd_data !== exp_rd || err_flags !== m_err) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_rx@%0d: got cnt=%0d rd=%h err=%b want cnt=%0d rd=%h err=%b",
                             n, rx_count, dev_rd_data, err_flags, m_rx.size(), exp_rd, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b0; dev_wr = 1'b0; dev_wr_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; dev_rd = 1'b0;
        m_err = 3'b000;
        #2;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_tx_full_wr_pop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        test_rx_filter();
        test_rx_overflow();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
